// File: rtl/control_sequencer.sv
// Multi-cycle control FSM for the SRC-style datapath: fetch T0..T2, then opcode-driven execute steps.
// Optional memory wait-states are enabled by defining CONTROL_SEQUENCER_MEM_WAIT_EN.
module control_sequencer #(
    parameter int         OPW    = 5,
    parameter logic [4:0] ADD_OP = 5'b00011
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        stop,
    input  logic        mem_ready,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        CONin,
    output logic        read,
    output logic        write,
    output logic [4:0]  alu_op,
    output logic        run
);
    localparam logic [3:0] S_RESET = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
                           S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd9;

    localparam logic [19:0] C_GRA = 20'h80000, C_GRB = 20'h40000, C_GRC = 20'h20000,
                            C_RIN = 20'h10000, C_ROUT = 20'h08000, C_BAOUT = 20'h04000,
                            C_COUT = 20'h02000, C_PCOUT = 20'h01000, C_PCIN = 20'h00800,
                            C_INCPC = 20'h00400, C_MARIN = 20'h00200, C_MDRIN = 20'h00100,
                            C_MDROUT = 20'h00080, C_IRIN = 20'h00040, C_YIN = 20'h00020,
                            C_ZIN = 20'h00010, C_ZLOW = 20'h00008, C_CONIN = 20'h00004,
                            C_READ = 20'h00002, C_WRITE = 20'h00001;

    logic [3:0]     state_reg, state_next;
    logic           con_reg;
    logic [OPW-1:0] opcode;
    logic           is_r, is_i, is_ld, is_ldi, is_st, is_br, is_jr, is_halt, exec_op;
    logic           last_step, mem_hold;
    logic [19:0]    ctl;
    logic           unused_ir;

    assign opcode    = ir[31:32-OPW];
    assign unused_ir = ^ir[31-OPW:0];

    always_comb begin
        is_r    = (opcode == OPW'(5'b00011)) || (opcode == OPW'(5'b00100)) ||
                  (opcode == OPW'(5'b00101)) || (opcode == OPW'(5'b00110)) ||
                  (opcode == OPW'(5'b00111)) || (opcode == OPW'(5'b01001));
        is_i    = (opcode == OPW'(5'b01100)) || (opcode == OPW'(5'b01101)) ||
                  (opcode == OPW'(5'b01110));
        is_ld   = (opcode == OPW'(5'b00000));
        is_ldi  = (opcode == OPW'(5'b00001));
        is_st   = (opcode == OPW'(5'b00010));
        is_br   = (opcode == OPW'(5'b10011));
        is_jr   = (opcode == OPW'(5'b10100));
        is_halt = (opcode == OPW'(5'b11011));
        exec_op = is_r || is_i || is_ld || is_ldi || is_st || is_br || is_jr;
    end

    // Final step of each instruction class; nop/undefined opcodes finish at T2.
    always_comb begin
        last_step = 1'b0;
        case (state_reg)
            S_T2:    last_step = !exec_op && !is_halt;
            S_T3:    last_step = is_jr;
            S_T5:    last_step = is_r || is_i || is_ldi;
            S_T6:    last_step = is_br;
            S_T7:    last_step = 1'b1;
            default: last_step = 1'b0;
        endcase
    end

`ifdef CONTROL_SEQUENCER_MEM_WAIT_EN
    assign mem_hold = !mem_ready && ((state_reg == S_T1) || ((state_reg == S_T6) && is_ld) ||
                                     ((state_reg == S_T7) && is_st));
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_hold         = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_RESET: state_next = S_T0;
            S_HALT:  state_next = S_HALT;
            default: begin
                if (mem_hold)
                    state_next = state_reg;
                else if ((state_reg == S_T2) && is_halt)
                    state_next = S_HALT;
                else if (last_step)
                    state_next = stop ? S_HALT : S_T0;
                else
                    state_next = state_reg + 4'd1;
            end
        endcase
    end

    // CON FF is sampled on each edge so the br T6 decision comes from state, not a live input.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_RESET;
            con_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            con_reg   <= con_ff;
        end
    end

    always_comb begin
        ctl    = 20'h0;
        alu_op = 5'b00000;
        case (state_reg)
            S_T0: ctl = C_PCOUT | C_MARIN | C_INCPC | C_ZIN;
            S_T1: ctl = C_ZLOW | C_PCIN | C_READ | C_MDRIN;
            S_T2: ctl = C_MDROUT | C_IRIN;
            S_T3: begin
                if (is_r || is_i)                 ctl = C_GRB | C_ROUT | C_YIN;
                else if (is_ld || is_ldi || is_st) ctl = C_GRB | C_BAOUT | C_YIN;
                else if (is_br)                   ctl = C_GRA | C_ROUT | C_CONIN;
                else if (is_jr)                   ctl = C_GRA | C_ROUT | C_PCIN;
            end
            S_T4: begin
                if (is_r) begin
                    ctl    = C_GRC | C_ROUT | C_ZIN;
                    alu_op = 5'(opcode);
                end else if (is_i) begin
                    ctl    = C_COUT | C_ZIN;
                    alu_op = 5'(opcode - OPW'(5'b01001));
                end else if (is_ld || is_ldi || is_st) begin
                    ctl    = C_COUT | C_ZIN;
                    alu_op = ADD_OP;
                end else if (is_br) begin
                    ctl    = C_PCOUT | C_YIN;
                end
            end
            S_T5: begin
                if (is_r || is_i || is_ldi)  ctl = C_ZLOW | C_GRA | C_RIN;
                else if (is_ld || is_st)     ctl = C_ZLOW | C_MARIN;
                else if (is_br) begin
                    ctl    = C_COUT | C_ZIN;
                    alu_op = ADD_OP;
                end
            end
            S_T6: begin
                if (is_ld)                  ctl = C_READ | C_MDRIN;
                else if (is_st)             ctl = C_GRA | C_ROUT | C_MDRIN;
                else if (is_br && con_reg)  ctl = C_ZLOW | C_PCIN;
            end
            S_T7: begin
                if (is_ld)       ctl = C_MDROUT | C_GRA | C_RIN;
                else if (is_st)  ctl = C_WRITE;
            end
            default: ctl = 20'h0;
        endcase
    end

    assign {Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC, MARin, MDRin, MDRout,
            IRin, Yin, Zin, Zlowout, CONin, read, write} = ctl;
    assign run = (state_reg != S_RESET) && (state_reg != S_HALT);
endmodule
